idbctl_flag_writer: RTL



---
 rtl/idbctl_pkg.sv | 18 +
 rtl/idbctl_flag_writer_if.sv | 23 ++
 rtl/idbctl_flag_merge.sv | 18 +
 rtl/idbctl_flag_writer.sv | 97 +++++++++
 4 files changed

// File: rtl/idbctl_pkg.sv
// Constants and types shared by the IDBCTL status-flag writer and its read selector.
package idbctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int FLAG_D   = 5;
  localparam int FLAG_M   = 4;
  localparam int FLAG_V   = 3;
  localparam int FLAG_S   = 2;
  localparam int FLAG_PCR = 1;
  localparam int FLAG_PGS = 0;
  localparam int FLAG_W   = 6;

endpackage

// File: rtl/idbctl_flag_writer_if.sv
// Request/acknowledge bus between a CPU-side requester and the flag writer.
interface idbctl_flag_writer_if;
  import idbctl_pkg::*;

  logic              wr_req;
  logic [FLAG_W-1:0] wr_sel;
  logic              idb_bit0;
  logic              idb_valid;
  logic              wr_ack;
  logic              wr_err;
  logic              busy;

  modport master (
    output wr_req, wr_sel, idb_bit0, idb_valid,
    input  wr_ack, wr_err, busy
  );

  modport slave (
    input  wr_req, wr_sel, idb_bit0, idb_valid,
    output wr_ack, wr_err, busy
  );

endinterface

// File: rtl/idbctl_flag_merge.sv
// Next value of one status flag: hardware clear beats hardware set beats software write.
module idbctl_flag_merge (
  input  logic cur,
  input  logic set,
  input  logic clr,
  input  logic wr_en,
  input  logic wr_data,
  output logic nxt
);

  always_comb begin
    nxt = cur;
    if (clr)        nxt = 1'b0;
    else if (set)   nxt = 1'b1;
    else if (wr_en) nxt = wr_data;
  end

endmodule

// File: rtl/idbctl_flag_writer.sv
// Six-flag status register loaded from IDB bit 0 under a bounded-wait handshake,
// with per-flag hardware set/clear events merged in every state.
module idbctl_flag_writer
  import idbctl_pkg::*;
#(
  parameter int                TIMEOUT   = 15,
  parameter logic [FLAG_W-1:0] RESET_VAL = '0
) (
  input  logic              sysclk,
  input  logic              sys_rst,
  idbctl_flag_writer_if.slave bus,
  input  logic [FLAG_W-1:0] hw_set,
  input  logic [FLAG_W-1:0] hw_clr,
  output logic [FLAG_W-1:0] flags
);

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [FLAG_W-1:0] sel_q, sel_nxt;
  logic [FLAG_W-1:0] flags_q, flags_nxt;
  logic              err_q, err_nxt;
  logic              commit;
  logic [FLAG_W-1:0] wr_mask;

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      flags_q <= RESET_VAL;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sel_q   <= sel_nxt;
      flags_q <= flags_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    err_nxt   = 1'b0;
    commit    = 1'b0;
    wr_mask   = sel_q;
    case (state)
      IDLE: begin
        // Same-cycle data bypasses the latch and commits straight from wr_sel.
        wr_mask = bus.wr_sel;
        if (bus.wr_req) begin
          if (bus.idb_valid) begin
            commit    = 1'b1;
            state_nxt = ACK;
          end else begin
            sel_nxt   = bus.wr_sel;
            cnt_nxt   = '0;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.idb_valid) begin
          commit    = 1'b1;
          state_nxt = ACK;
        end else if (cnt == CNT_MAX) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < FLAG_W; i++) begin : g_merge
    idbctl_flag_merge u_merge (
      .cur     (flags_q[i]),
      .set     (hw_set[i]),
      .clr     (hw_clr[i]),
      .wr_en   (commit & wr_mask[i]),
      .wr_data (bus.idb_bit0),
      .nxt     (flags_nxt[i])
    );
  end

  assign flags      = flags_q;
  assign bus.wr_ack = (state == ACK);
  assign bus.busy   = (state != IDLE);
  assign bus.wr_err = err_q;

endmodule
